iob_sim_ctrl: RTL

IOB_SIM_CTRL -- requirements
Module: iob_sim_ctrl

---
 rtl/iob_sim_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/iob_sim_ctrl.sv
// Simulation controller: watches per-CPU trap lines, asserts a sticky
// end-of-simulation request after a hold-off delay, provides a divided clock
// and exposes status/counters through an IOb native CSR slave.
// Optional watchdog compiled in with IOB_SIM_CTRL_TIMEOUT_EN.
// Ports:
//   clk_i, rst_n_i         system clock, synchronous active-low reset
//   trap_i                 per-channel trap levels
//   iob_*                  IOb native slave (avalid/addr/wdata/wstrb in,
//                          rdata/ready/rvalid out)
//   div_clk_o              clk_i divided by CLK_DIV, 50% duty
//   done_o                 sticky end-of-simulation request
//   trap_id_o              first trapping channel, 4'hF for watchdog expiry
//   timeout_o              watchdog expiry flag
module iob_sim_ctrl #(
    parameter int unsigned N_TRAP  = 2,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned HOLDOFF = 10,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [N_TRAP-1:0]     trap_i,
    input  logic                  iob_avalid_i,
    input  logic [3:0]            iob_addr_i,
    input  logic [DATA_W-1:0]     iob_wdata_i,
    input  logic [DATA_W/8-1:0]   iob_wstrb_i,
    output logic [DATA_W-1:0]     iob_rdata_o,
    output logic                  iob_ready_o,
    output logic                  iob_rvalid_o,
    output logic                  div_clk_o,
    output logic                  done_o,
    output logic [3:0]            trap_id_o,
    output logic                  timeout_o
);

    localparam int unsigned HALF   = CLK_DIV / 2;
    localparam int unsigned DIV_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [HOLD_W-1:0]   hold_cnt, hold_next;
    logic [3:0]          trap_id_next;
    logic                timeout_next;
    logic [DIV_W-1:0]    div_cnt;
    logic [N_TRAP-1:0]   trap_prev;
    logic [N_TRAP-1:0]   trap_mask;
    logic [31:0]         cycle_cnt;

    logic [N_TRAP-1:0]   edge_c;
    logic [3:0]          first_id_c;
    logic [31:0]         wdata_c;
    logic [3:0]          wstrb_c;
    logic                read_c, write_c, clear_c, timeout_hit_c;
    logic [DATA_W-1:0]   rd_data_c;

    assign wdata_c = 32'(iob_wdata_i);
    assign wstrb_c = 4'(iob_wstrb_i);
    assign read_c  = iob_avalid_i && (iob_wstrb_i == '0);
    assign write_c = iob_avalid_i && (iob_wstrb_i != '0);
    assign clear_c = write_c && (iob_addr_i == 4'h0) && wstrb_c[0] && wdata_c[0];
    assign edge_c  = trap_i & ~trap_prev;

`ifdef IOB_SIM_CTRL_TIMEOUT_EN
    logic [31:0] timeout_limit;
    assign timeout_hit_c = (timeout_limit != '0) && (cycle_cnt == timeout_limit)
                           && (state != DONE);
`else
    logic unused_c;
    assign timeout_hit_c = 1'b0;
    assign unused_c      = ^{wdata_c[31:1], wstrb_c[3:1]};
`endif

    // Lowest-index channel among simultaneous rising edges
    always_comb begin
        first_id_c = 4'd0;
        for (int i = N_TRAP - 1; i >= 0; i--) begin
            if (edge_c[i]) first_id_c = 4'(i);
        end
    end

    // Next-state logic; a trap edge outranks a watchdog hit, soft clear outranks all
    always_comb begin
        state_next   = state;
        hold_next    = hold_cnt;
        trap_id_next = trap_id_o;
        timeout_next = timeout_o;
        if (clear_c) begin
            state_next   = IDLE;
            hold_next    = '0;
            trap_id_next = 4'd0;
            timeout_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (edge_c != '0) begin
                        state_next   = HOLD;
                        hold_next    = '0;
                        trap_id_next = first_id_c;
                    end else if (timeout_hit_c) begin
                        state_next   = DONE;
                        timeout_next = 1'b1;
                        trap_id_next = 4'hF;
                    end
                end
                HOLD: begin
                    if (timeout_hit_c && (edge_c == '0)) begin
                        state_next   = DONE;
                        timeout_next = 1'b1;
                        trap_id_next = 4'hF;
                    end else if (hold_cnt == HOLD_W'(HOLDOFF - 1)) begin
                        state_next = DONE;
                    end else begin
                        hold_next = HOLD_W'(hold_cnt + 1'b1);
                    end
                end
                default: state_next = DONE;
            endcase
        end
    end

    // CSR read mux
    always_comb begin
        rd_data_c = '0;
        case (iob_addr_i)
            4'h0: rd_data_c = DATA_W'({timeout_o, done_o, 2'(state)});
            4'h4: rd_data_c = DATA_W'(trap_mask);
`ifdef IOB_SIM_CTRL_TIMEOUT_EN
            4'h8: rd_data_c = DATA_W'(timeout_limit);
`endif
            4'hC: rd_data_c = DATA_W'(cycle_cnt);
            default: rd_data_c = '0;
        endcase
    end

    // State register, counters, CSRs and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            trap_id_o    <= 4'd0;
            timeout_o    <= 1'b0;
            done_o       <= 1'b0;
            div_cnt      <= '0;
            div_clk_o    <= 1'b0;
            trap_prev    <= '0;
            trap_mask    <= '0;
            cycle_cnt    <= '0;
            iob_ready_o  <= 1'b0;
            iob_rvalid_o <= 1'b0;
            iob_rdata_o  <= '0;
`ifdef IOB_SIM_CTRL_TIMEOUT_EN
            timeout_limit <= '0;
`endif
        end else begin
            state     <= state_next;
            hold_cnt  <= hold_next;
            trap_id_o <= trap_id_next;
            timeout_o <= timeout_next;
            done_o    <= (state_next == DONE);
            trap_prev <= trap_i;

            if (div_cnt == DIV_W'(HALF - 1)) begin
                div_cnt   <= '0;
                div_clk_o <= ~div_clk_o;
            end else begin
                div_cnt <= DIV_W'(div_cnt + 1'b1);
            end

            if (clear_c) begin
                trap_mask <= '0;
                cycle_cnt <= '0;
            end else begin
                trap_mask <= trap_mask | edge_c;
                if ((state != DONE) && (cycle_cnt != 32'hFFFF_FFFF)) begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                end
            end

            iob_ready_o  <= 1'b1;
            iob_rvalid_o <= read_c;
            if (read_c) iob_rdata_o <= rd_data_c;

`ifdef IOB_SIM_CTRL_TIMEOUT_EN
            if (write_c && (iob_addr_i == 4'h8)) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb_c[b]) timeout_limit[8*b +: 8] <= wdata_c[8*b +: 8];
                end
            end
`endif
        end
    end

endmodule
